// File: rtl/threepa_pkg.sv
// Shared constants and helpers for the operand issue stage and its register scoreboard.
package threepa_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    // Register 0 is hardwired to zero: never read, never tracked as busy.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/operand_issue_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register plus
// combinational hazard lookups that already account for a same-cycle writeback.
module reg_scoreboard #(
    parameter int ADDR_W = threepa_pkg::ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_set,
    input  logic [ADDR_W-1:0]       i_set_addr,
    input  logic                    i_clr,
    input  logic [ADDR_W-1:0]       i_clr_addr,
    input  logic                    i_clr2,
    input  logic [ADDR_W-1:0]       i_clr2_addr,
    input  logic [ADDR_W-1:0]       i_rs1,
    input  logic [ADDR_W-1:0]       i_rs2,
    input  logic [ADDR_W-1:0]       i_rd,
    output logic [2**ADDR_W-1:0]    o_busy,
    output logic                    o_pend_rs1,
    output logic                    o_pend_rs2,
    output logic                    o_pend_rd
);
    import threepa_pkg::*;

    logic [2**ADDR_W-1:0] r_busy;
    logic [2**ADDR_W-1:0] w_busy_next;

    function automatic logic lookup(input logic [ADDR_W-1:0] addr,
                                    input logic [2**ADDR_W-1:0] busy,
                                    input logic clr,
                                    input logic [ADDR_W-1:0] clr_addr);
        return !is_zero_reg(addr) && busy[addr] && !(clr && clr_addr == addr);
    endfunction

    // NOTE: every bit gets the current value first so no path leaves w_busy_next unassigned (no latch).
    always_comb begin
        w_busy_next = r_busy;
        if (i_clr)
            w_busy_next[i_clr_addr] = 1'b0;
        if (i_clr2)
            w_busy_next[i_clr2_addr] = 1'b0;
        // Set is applied last so a same-cycle set and clear of one register leaves it busy.
        if (i_set)
            w_busy_next[i_set_addr] = 1'b1;
        w_busy_next[0] = 1'b0;
    end

    // NOTE: state uses non-blocking assignment; the busy vector is small control state, so it is reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_busy <= '0;
        else
            r_busy <= w_busy_next;
    end

    assign o_busy     = r_busy;
    assign o_pend_rs1 = lookup(i_rs1, r_busy, i_clr, i_clr_addr);
    assign o_pend_rs2 = lookup(i_rs2, r_busy, i_clr, i_clr_addr);
    assign o_pend_rd  = lookup(i_rd,  r_busy, i_clr, i_clr_addr);

endmodule

// File: rtl/operand_issue.sv
// Decode-stage operand fetch/issue: resolves operands with writeback bypass,
// stalls on RAW/WAW hazards via the scoreboard, and launches into a registered ID/EX slot.
module operand_issue #(
    parameter int DATA_W = threepa_pkg::DATA_W,
    parameter int ADDR_W = threepa_pkg::ADDR_W,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iValid,
    output logic              oReady,
    input  logic [ADDR_W-1:0] iRs1,
    input  logic [ADDR_W-1:0] iRs2,
    input  logic [ADDR_W-1:0] iRd,
    input  logic              iRdWe,
    input  logic [DATA_W-1:0] iImm,
    input  logic [CTRL_W-1:0] iCtrl,
    output logic [ADDR_W-1:0] oRAddr1,
    output logic [ADDR_W-1:0] oRAddr2,
    input  logic [DATA_W-1:0] iRData1,
    input  logic [DATA_W-1:0] iRData2,
    input  logic              iWbValid,
    input  logic [ADDR_W-1:0] iWbAddr,
    input  logic [DATA_W-1:0] iWbData,
    input  logic              iFlush,
    output logic              oValid,
    input  logic              iReady,
    output logic [DATA_W-1:0] oOpA,
    output logic [DATA_W-1:0] oOpB,
    output logic [DATA_W-1:0] oImm,
    output logic [CTRL_W-1:0] oCtrl,
    output logic [ADDR_W-1:0] oRd,
    output logic              oRdWe
);
    import threepa_pkg::*;

    logic                 r_valid;
    logic [DATA_W-1:0]    r_op_a;
    logic [DATA_W-1:0]    r_op_b;
    logic [DATA_W-1:0]    r_imm;
    logic [CTRL_W-1:0]    r_ctrl;
    logic [ADDR_W-1:0]    r_rd;
    logic                 r_rd_we;

    logic [2**ADDR_W-1:0] w_busy;
    logic                 w_pend_rs1;
    logic                 w_pend_rs2;
    logic                 w_pend_rd;
    logic                 w_hazard;
    logic                 w_slot_free;
    logic                 w_issue;
    logic                 w_set;
    logic                 w_flush_clr;
    logic [DATA_W-1:0]    w_op_a;
    logic [DATA_W-1:0]    w_op_b;

    assign oRAddr1 = iRs1;
    assign oRAddr2 = iRs2;

    always_comb begin
        w_op_a = iRData1;
        if (is_zero_reg(iRs1))
            w_op_a = '0;
        else if (iWbValid && iWbAddr == iRs1)
            w_op_a = iWbData;
    end

    always_comb begin
        w_op_b = iRData2;
        if (is_zero_reg(iRs2))
            w_op_b = '0;
        else if (iWbValid && iWbAddr == iRs2)
            w_op_b = iWbData;
    end

    // oReady never looks at iValid, so fetch may wait for it without a combinational loop.
    assign w_hazard    = w_pend_rs1 || w_pend_rs2 || (iRdWe && w_pend_rd);
    assign w_slot_free = !r_valid || iReady;
    assign oReady      = w_slot_free && !w_hazard && !iFlush;
    assign w_issue     = iValid && oReady;
    assign w_set       = w_issue && iRdWe && !is_zero_reg(iRd);
    assign w_flush_clr = iFlush && r_valid && r_rd_we;

    reg_scoreboard #(
        .ADDR_W(ADDR_W)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .i_set      (w_set),
        .i_set_addr (iRd),
        .i_clr      (iWbValid),
        .i_clr_addr (iWbAddr),
        .i_clr2     (w_flush_clr),
        .i_clr2_addr(r_rd),
        .i_rs1      (iRs1),
        .i_rs2      (iRs2),
        .i_rd       (iRd),
        .o_busy     (w_busy),
        .o_pend_rs1 (w_pend_rs1),
        .o_pend_rs2 (w_pend_rs2),
        .o_pend_rd  (w_pend_rd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_imm   <= '0;
            r_ctrl  <= '0;
            r_rd    <= '0;
            r_rd_we <= 1'b0;
        end else if (w_issue) begin
            r_valid <= 1'b1;
            r_op_a  <= w_op_a;
            r_op_b  <= w_op_b;
            r_imm   <= iImm;
            r_ctrl  <= iCtrl;
            r_rd    <= iRd;
            r_rd_we <= iRdWe;
        end else if (iFlush || iReady) begin
            r_valid <= 1'b0;
        end
    end

    assign oValid = r_valid;
    assign oOpA   = r_op_a;
    assign oOpB   = r_op_b;
    assign oImm   = r_imm;
    assign oCtrl  = r_ctrl;
    assign oRd    = r_rd;
    assign oRdWe  = r_rd_we;

endmodule

// File: tb/tb_operand_issue.sv
// Bench for operand_issue: directed vector table, async reset checks, then random
// traffic compared against a rule-level model of slot, scoreboard and bypass.
module tb_operand_issue;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 8;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          iValid, oReady;
    logic [AW-1:0] iRs1, iRs2, iRd;
    logic          iRdWe;
    logic [DW-1:0] iImm;
    logic [CW-1:0] iCtrl;
    logic [AW-1:0] oRAddr1, oRAddr2;
    logic [DW-1:0] iRData1, iRData2;
    logic          iWbValid;
    logic [AW-1:0] iWbAddr;
    logic [DW-1:0] iWbData;
    logic          iFlush, oValid, iReady;
    logic [DW-1:0] oOpA, oOpB, oImm;
    logic [CW-1:0] oCtrl;
    logic [AW-1:0] oRd;
    logic          oRdWe;

    logic [DW-1:0] rf [NR];
    assign iRData1 = rf[oRAddr1];
    assign iRData2 = rf[oRAddr2];

    always #5 clk = ~clk;

    operand_issue #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW)) dut (
        .clk(clk), .reset(reset), .iValid(iValid), .oReady(oReady),
        .iRs1(iRs1), .iRs2(iRs2), .iRd(iRd), .iRdWe(iRdWe), .iImm(iImm), .iCtrl(iCtrl),
        .oRAddr1(oRAddr1), .oRAddr2(oRAddr2), .iRData1(iRData1), .iRData2(iRData2),
        .iWbValid(iWbValid), .iWbAddr(iWbAddr), .iWbData(iWbData), .iFlush(iFlush),
        .oValid(oValid), .iReady(iReady), .oOpA(oOpA), .oOpB(oOpB), .oImm(oImm),
        .oCtrl(oCtrl), .oRd(oRd), .oRdWe(oRdWe)
    );

    // Reference state: what the ID/EX slot and the set of in-flight destinations should be.
    logic          m_valid;
    logic [DW-1:0] m_opa, m_opb, m_imm;
    logic [CW-1:0] m_ctrl;
    logic [AW-1:0] m_rd;
    logic          m_rdwe;
    logic [NR-1:0] m_busy;
    logic          last_ready;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        else
            n_pass++;
    endtask

    function automatic logic wb_hits(input logic [AW-1:0] a);
        return iWbValid && iWbAddr == a;
    endfunction

    function automatic logic m_pending(input logic [AW-1:0] a);
        return a != 0 && m_busy[a] && !wb_hits(a);
    endfunction

    function automatic logic [DW-1:0] m_operand(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (wb_hits(a)) return iWbData;
        return rf[a];
    endfunction

    function automatic logic m_ready();
        logic hazard;
        hazard = m_pending(iRs1) || m_pending(iRs2) || (iRdWe && m_pending(iRd));
        return (!m_valid || iReady) && !hazard && !iFlush;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_opa = '0; m_opb = '0; m_imm = '0;
        m_ctrl = '0; m_rd = '0; m_rdwe = 1'b0; m_busy = '0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_oValid"}, oValid, m_valid);
        check({tag, "_busy"}, dut.w_busy, m_busy);
        if (m_valid) begin
            check({tag, "_oOpA"}, oOpA, m_opa);
            check({tag, "_oOpB"}, oOpB, m_opb);
            check({tag, "_fields"}, {oImm, oCtrl, oRd, oRdWe}, {m_imm, m_ctrl, m_rd, m_rdwe});
        end
    endtask

    // One clock: inputs are already driven; checks oReady, advances DUT and model together.
    task automatic step(input string tag);
        logic          e_ready, issue;
        logic [NR-1:0] nb;
        logic [DW-1:0] na, nbop;
        #1;
        e_ready = m_ready();
        check({tag, "_oReady"}, oReady, e_ready);
        check({tag, "_oRAddr"}, {oRAddr1, oRAddr2}, {iRs1, iRs2});
        last_ready = oReady;
        issue = iValid && e_ready;
        nb = m_busy;
        if (iWbValid) nb[iWbAddr] = 1'b0;
        if (iFlush && m_valid && m_rdwe) nb[m_rd] = 1'b0;
        if (issue && iRdWe && iRd != 0) nb[iRd] = 1'b1;
        na   = m_operand(iRs1);
        nbop = m_operand(iRs2);
        @(posedge clk);
        m_busy = nb;
        if (issue) begin
            m_valid = 1'b1; m_opa = na; m_opb = nbop; m_imm = iImm;
            m_ctrl = iCtrl; m_rd = iRd; m_rdwe = iRdWe;
        end else if (iFlush || iReady) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        if (iWbValid && iWbAddr != 0) rf[iWbAddr] = iWbData;
        check_outputs(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_oValid"}, oValid, 1'b0);
        check({tag, "_busy"}, dut.w_busy, '0);
        check({tag, "_data"}, {oOpA, oOpB, oImm}, '0);
        check({tag, "_ctrl"}, {oCtrl, oRd, oRdWe}, '0);
    endtask

    typedef struct {
        logic          v;
        logic [AW-1:0] rs1, rs2, rd;
        logic          we, wbv;
        logic [AW-1:0] wba;
        logic [DW-1:0] wbd;
        logic          fl, rdy;
        logic          e_rdy, e_val;
        logic [DW-1:0] e_opa, e_opb;
    } vec_t;

    vec_t vecs[20];

    initial begin
        // v rs1 rs2 rd we | wbv wba wbd | fl rdy | e_rdy e_val e_opa e_opb
        vecs[0]  = '{1, 2, 1, 0, 0,  0, 0, 0,     0, 1,  1, 1, 1,    2};
        vecs[1]  = '{1, 0, 0, 3, 1,  0, 0, 0,     0, 1,  1, 1, 0,    0};
        vecs[2]  = '{1, 3, 0, 0, 0,  0, 0, 0,     0, 1,  0, 0, 0,    0};
        vecs[3]  = '{1, 3, 0, 0, 0,  0, 0, 0,     0, 1,  0, 0, 0,    0};
        vecs[4]  = '{1, 3, 0, 0, 0,  1, 3, 'h55,  0, 1,  1, 1, 'h55, 0};
        vecs[5]  = '{1, 0, 0, 0, 1,  0, 0, 0,     0, 1,  1, 1, 0,    0};
        vecs[6]  = '{1, 0, 0, 0, 0,  0, 0, 0,     0, 1,  1, 1, 0,    0};
        vecs[7]  = '{1, 1, 2, 5, 1,  0, 0, 0,     0, 1,  1, 1, 2,    1};
        vecs[8]  = '{1, 0, 0, 5, 1,  0, 0, 0,     0, 1,  0, 0, 0,    0};
        vecs[9]  = '{1, 0, 0, 5, 1,  1, 5, 'h77,  0, 1,  1, 1, 0,    0};
        vecs[10] = '{1, 5, 0, 0, 0,  0, 0, 0,     0, 1,  0, 0, 0,    0};
        vecs[11] = '{0, 0, 0, 0, 0,  1, 5, 'h99,  0, 1,  1, 0, 0,    0};
        vecs[12] = '{1, 4, 3, 6, 1,  0, 0, 0,     0, 1,  1, 1, 44,   'h55};
        vecs[13] = '{1, 1, 1, 0, 0,  0, 0, 0,     0, 0,  0, 1, 44,   'h55};
        vecs[14] = '{1, 1, 1, 0, 0,  0, 0, 0,     0, 0,  0, 1, 44,   'h55};
        vecs[15] = '{1, 1, 1, 0, 0,  0, 0, 0,     0, 0,  0, 1, 44,   'h55};
        vecs[16] = '{1, 1, 1, 0, 0,  0, 0, 0,     0, 1,  1, 1, 2,    2};
        vecs[17] = '{1, 0, 0, 4, 1,  0, 0, 0,     0, 1,  1, 1, 0,    0};
        vecs[18] = '{1, 4, 0, 0, 0,  0, 0, 0,     1, 0,  0, 0, 0,    0};
        vecs[19] = '{1, 4, 0, 0, 0,  0, 0, 0,     0, 1,  1, 1, 44,   0};

        for (int i = 0; i < NR; i++) rf[i] = 32'h1111 * i;
        rf[0] = 32'hFFFF_FFFF; rf[1] = 2; rf[2] = 1; rf[3] = 33; rf[4] = 44; rf[5] = 55;

        reset = 1'b0;
        iValid = 1'b1; iRs1 = 2; iRs2 = 1; iRd = 3; iRdWe = 1'b1;
        iImm = '0; iCtrl = '0; iWbValid = 1'b0; iWbAddr = '0; iWbData = '0;
        iFlush = 1'b0; iReady = 1'b1;
        model_reset();
        #2;
        check_all_zero("reset_init");
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset_held");
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            iValid = vecs[i].v; iRs1 = vecs[i].rs1; iRs2 = vecs[i].rs2;
            iRd = vecs[i].rd; iRdWe = vecs[i].we;
            iWbValid = vecs[i].wbv; iWbAddr = vecs[i].wba; iWbData = vecs[i].wbd;
            iFlush = vecs[i].fl; iReady = vecs[i].rdy;
            iImm = 32'hA000_0000 + 32'(i); iCtrl = 8'(i);
            step($sformatf("vec%0d", i));
            check($sformatf("vec%0d_ready", i), last_ready, vecs[i].e_rdy);
            check($sformatf("vec%0d_valid", i), oValid, vecs[i].e_val);
            if (vecs[i].e_val) begin
                check($sformatf("vec%0d_opa", i), oOpA, vecs[i].e_opa);
                check($sformatf("vec%0d_opb", i), oOpB, vecs[i].e_opb);
            end
        end

        // Slot is occupied and busy[6] is set here; reset must clear both without a clock edge.
        iValid = 1'b1; iFlush = 1'b0; iWbValid = 1'b0; iReady = 1'b0;
        reset = 1'b0;
        #1;
        check_all_zero("reset_async");
        model_reset();
        @(negedge clk);
        check_all_zero("reset_async_held");
        reset = 1'b1;
        iReady = 1'b1;

        for (int i = 0; i < 600; i++) begin
            iValid   = $urandom_range(3, 0) != 0;
            iRs1     = 5'($urandom_range(7, 0));
            iRs2     = 5'($urandom_range(7, 0));
            iRd      = 5'($urandom_range(7, 0));
            iRdWe    = $urandom_range(1, 0) != 0;
            iImm     = $urandom;
            iCtrl    = 8'($urandom);
            iWbValid = $urandom_range(2, 0) == 0;
            iWbAddr  = 5'($urandom_range(7, 0));
            iWbData  = $urandom;
            iFlush   = $urandom_range(15, 0) == 0;
            iReady   = $urandom_range(3, 0) != 0;
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/operand_issue.md
Name: operand_issue

Overview:
- Decode-stage operand fetch/issue block; sits directly downstream of the register file and upstream of execute.
- Accepts decoded instruction fields from fetch and drives the register-file read addresses.
- Bypasses same-cycle writeback data, tracks pending destination writes in a scoreboard, and stalls on RAW/WAW hazards.
- Launches operands into a registered ID/EX slot with valid/ready handshake.

Parameters:
- DATA_W, 32, operand/register width
- ADDR_W, 5, register address width (2**ADDR_W registers)
- CTRL_W, 8, opaque execute control bundle width, passed through unmodified

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous active-low reset
- iValid  input  1  decoded instruction valid from fetch
- oReady  output  1  instruction accepted this cycle when iValid&&oReady
- iRs1  input  ADDR_W  source register 1
- iRs2  input  ADDR_W  source register 2
- iRd  input  ADDR_W  destination register
- iRdWe  input  1  instruction writes iRd
- iImm  input  DATA_W  immediate, passed through
- iCtrl  input  CTRL_W  control bundle, passed through
- oRAddr1  output  ADDR_W  register-file read address 1
- oRAddr2  output  ADDR_W  register-file read address 2
- iRData1  input  DATA_W  register-file read data 1 (combinational from oRAddr1)
- iRData2  input  DATA_W  register-file read data 2
- iWbValid  input  1  writeback commits this cycle
- iWbAddr  input  ADDR_W  writeback register
- iWbData  input  DATA_W  writeback data
- iFlush  input  1  kill ID/EX slot and the instruction being offered
- oValid  output  1  ID/EX slot holds an instruction
- iReady  input  1  execute accepts slot
- oOpA, oOpB  output  DATA_W  resolved operands
- oImm  output  DATA_W  registered immediate
- oCtrl  output  CTRL_W  registered control bundle
- oRd  output  ADDR_W  registered destination
- oRdWe  output  1  registered destination write enable

Behaviour:
- oRAddr1=iRs1, oRAddr2=iRs2; combinational, no gating.
- Operand select, per source: if rs==0 then 0; else if iWbValid && iWbAddr==rs && iWbAddr!=0 then iWbData; else iRData.
- Scoreboard busy[2**ADDR_W-1:0]; bit 0 is never set.
- A source is pending when rs!=0, busy[rs]=1, and it is not cleared by a same-cycle writeback to rs.
- Hazard: either source pending (RAW), or iRdWe && iRd!=0 && busy[iRd] not cleared this cycle (WAW).
- Slot free: !oValid || iReady.
- oReady = slot free && !hazard && !iFlush. Combinational; may depend on iValid-independent inputs only.
- Issue = iValid && oReady.
  - Next edge: slot loads operands/fields, oValid=1.
  - If iRdWe && iRd!=0, busy[iRd] is set.
- No issue and iReady: oValid clears.
- No issue and !iReady: slot holds, all outputs stable.
- Latency: accept to oValid is 1 cycle.
- Writeback with iWbValid clears busy[iWbAddr]. Clearing an idle bit is a no-op.
- Same-cycle set and clear of the same bit: set wins.
- Flush:
  - oValid clears next edge.
  - If oValid && oRdWe, busy[oRd] clears.
  - No issue that cycle.
  - Writeback clears are still honoured.
- Reset (any time, asynchronous):
  - oValid=0, busy=0.
  - oOpA, oOpB, oImm, oCtrl, oRd, oRdWe all 0.
  - A pending instruction is lost.
- Outputs other than oReady and oRAddr are registered.

Decomposition:
- Shared package threepa_pkg holds:
  - constants DATA_W=32, ADDR_W=5, NUM_REGS=32
  - function for zero-register test
- One sub-module: reg_scoreboard.
  - Inputs: set, set_addr, clr, clr_addr, clr2 (flush), clr2_addr.
  - Outputs: busy vector, plus combinational per-address pending lookups for rs1, rs2, rd.

Test Plan:
- Reset low with iValid=1 -> oValid=0, busy=0, outputs 0; release reset, issue rs1=2,rs2=1 with RF data 1/2 -> next cycle oOpA=1, oOpB=2, oValid=1.
- Issue rd=3 write, then next instruction rs1=3 -> oReady=0 until iWbValid addr 3 data 0x55; in that cycle oReady=1 and oOpA=0x55 (bypass).
- rs1=0 with RF read data 0xFFFF_FFFF -> oOpA=0; rd=0 write -> busy stays 0, no stall on later rs=0.
- iReady=0 for 3 cycles while oValid=1 -> outputs held, oReady=0; iReady=1 -> slot drains or refills same edge.
- Issue rd=4 then iFlush while in slot -> oValid=0, busy[4]=0; following rs1=4 issues without stall.
- WAW: issue rd=5, then instruction rd=5 -> stalled until writeback addr 5; same-cycle clear+set leaves busy[5]=1.
